// File: rtl/arqt_buttons.sv
// Avalon-MM input PIO: synchronized, optionally debounced inputs with edge capture and level irq.
// Define ARQT_BTN_DEBOUNCE_EN to build the per-bit debounce counters.
module arqt_buttons #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic             wr_en;
  logic             unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef ARQT_BTN_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt [WIDTH];

  // A bit only follows sync2 after it has disagreed for DEBOUNCE_CYCLES clocks in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable <= '0;
    else          stable <= sync2;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable_d <= '0;
    else          stable_d <= stable;
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  always_comb begin
    ev = rise | fall;
    case (EDGE_TYPE)
      0:       ev = rise;
      1:       ev = fall;
      default: ev = rise | fall;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_mask <= '0;
    else if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
  end

  // New events are OR-ed in after the clear so a same-cycle event survives the W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else if (wr_en && address == 2'd3) begin
      edge_capture <= (edge_capture & ~writedata[WIDTH-1:0]) | ev;
    end else begin
      edge_capture <= edge_capture | ev;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_capture;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
